// File: rtl/hdr_exit_restart_gen_if.sv
// HDR Exit/Restart generator interface: command handshake plus bus drive values.
// Latency: n/a (wiring only).
// Backpressure: none. The controller may pulse a start at any time, and the generator drops any start it cannot take.
//
// Signals
//   i_gen_start/i_gen_type/i_gen_abort : controller -> generator command
//   o_scl/o_sda/o_bus_oe              : generator -> SDR/HDR bus mux
//   o_gen_busy/o_gen_done             : generator -> controller status
//   HDR_EXIT_GEN_STATUS_EN adds o_start_dropped and o_phase_idx.
`timescale 1ns/1ps
interface hdr_exit_restart_gen_if;
  logic       i_gen_start;
  logic       i_gen_type;
  logic       i_gen_abort;
  logic       o_scl;
  logic       o_sda;
  logic       o_bus_oe;
  logic       o_gen_busy;
  logic       o_gen_done;
`ifdef HDR_EXIT_GEN_STATUS_EN
  logic       o_start_dropped;
  logic [3:0] o_phase_idx;
`endif

  // Controller side
  modport master (
    output i_gen_start, i_gen_type, i_gen_abort,
    input  o_scl, o_sda, o_bus_oe, o_gen_busy, o_gen_done
`ifdef HDR_EXIT_GEN_STATUS_EN
    , input o_start_dropped, o_phase_idx
`endif
  );

  // Generator side
  modport slave (
    input  i_gen_start, i_gen_type, i_gen_abort,
    output o_scl, o_sda, o_bus_oe, o_gen_busy, o_gen_done
`ifdef HDR_EXIT_GEN_STATUS_EN
    , output o_start_dropped, o_phase_idx
`endif
  );
endinterface

// File: rtl/hdr_exit_restart_gen.sv
// I3C HDR Exit / HDR Restart bus pattern generator (controller transmit side).
// Latency: outputs are registered. Busy lasts 10*PHASE_CYCLES cycles (Exit) or 7*PHASE_CYCLES cycles (Restart), then done pulses for 1 cycle.
// Backpressure: none. A start is taken only in IDLE, and a start arriving while busy or in DONE is dropped, not queued.
//
// Ports
//   i_sys_clk : system clock, rising edge
//   i_sys_rst : asynchronous active-high reset
//   gen_if    : hdr_exit_restart_gen_if.slave
//               (start/type/abort in; scl/sda/oe/busy/done out)
// Optional: define HDR_EXIT_GEN_STATUS_EN for the o_start_dropped and o_phase_idx status outputs.
`timescale 1ns/1ps
module hdr_exit_restart_gen #(
  parameter int PHASE_CYCLES = 2,   // cycles per bus phase, 1..15
  parameter int CNT_W        = 4    // hold counter width, 2^CNT_W > PHASE_CYCLES
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  hdr_exit_restart_gen_if.slave gen_if
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_TOGGLE = 3'd2;
  localparam logic [2:0] ST_SCL_HI = 3'd3;
  localparam logic [2:0] ST_SDA_HI = 3'd4;
  localparam logic [2:0] ST_SCL_LO = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [2:0]       TOG_EXIT    = 3'd7;
  localparam logic [2:0]       TOG_RESTART = 3'd3;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       tog_q, tog_d;
  logic             type_q, type_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;       // start taken this cycle
  logic             adv;          // moving into a new phase this cycle
  logic             phase_end;
  logic             last_toggle;

  assign phase_end   = (hold_q == HOLD_LAST);
  assign last_toggle = (tog_q == (type_q ? TOG_RESTART : TOG_EXIT));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tog_d   = tog_q;
    type_d  = type_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    adv     = 1'b0;

    if ((state_q != ST_IDLE) && gen_if.i_gen_abort) begin
      // Abort beats any phase advance. Release the bus with no done pulse.
      state_d = ST_IDLE;
      hold_d  = '0;
      tog_d   = '0;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          scl_d  = 1'b1;
          sda_d  = 1'b1;
          oe_d   = 1'b0;
          busy_d = 1'b0;
          hold_d = '0;
          // A start that coincides with an abort is dropped.
          if (gen_if.i_gen_start && !gen_if.i_gen_abort) begin
            accept  = 1'b1;
            type_d  = gen_if.i_gen_type;
            tog_d   = '0;
            state_d = ST_PRE;
            scl_d   = 1'b0;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          hold_d  = '0;
          tog_d   = '0;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end

        default: begin
          if (!phase_end) begin
            hold_d = hold_q + CNT_W'(1);
          end else begin
            hold_d = '0;
            adv    = 1'b1;
            case (state_q)
              ST_PRE: begin
                // The first toggle happens on entry to TOGGLE.
                state_d = ST_TOGGLE;
                sda_d   = ~sda_q;
                tog_d   = 3'd1;
              end
              ST_TOGGLE: begin
                if (last_toggle) begin
                  state_d = ST_SCL_HI;
                  scl_d   = 1'b1;
                end else begin
                  sda_d = ~sda_q;
                  tog_d = tog_q + 3'd1;
                end
              end
              ST_SCL_HI: begin
                // SDA rising with SCL high: STOP for Exit, Sr for Restart.
                state_d = ST_SDA_HI;
                sda_d   = 1'b1;
              end
              ST_SDA_HI: begin
                if (type_q) begin
                  state_d = ST_SCL_LO;
                  scl_d   = 1'b0;
                end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  oe_d    = 1'b0;
                  busy_d  = 1'b0;
                end
              end
              ST_SCL_LO: begin
                state_d = ST_DONE;
                scl_d   = 1'b1;
                done_d  = 1'b1;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
              end
              default: begin
                state_d = ST_IDLE;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                adv     = 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      tog_q   <= '0;
      type_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tog_q   <= tog_d;
      type_q  <= type_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gen_if.o_scl      = scl_q;
  assign gen_if.o_sda      = sda_q;
  assign gen_if.o_bus_oe   = oe_q;
  assign gen_if.o_gen_busy = busy_q;
  assign gen_if.o_gen_done = done_q;

`ifdef HDR_EXIT_GEN_STATUS_EN
  logic       dropped_q;
  logic [3:0] phase_idx_q;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      dropped_q   <= 1'b0;
      phase_idx_q <= 4'd0;
    end else begin
      // Any start that is not accepted is a drop: busy, DONE, or lost to abort.
      if (accept) begin
        dropped_q <= 1'b0;
      end else if (gen_if.i_gen_start) begin
        dropped_q <= 1'b1;
      end

      if (accept) begin
        phase_idx_q <= 4'd1;
      end else if (state_d == ST_IDLE) begin
        phase_idx_q <= 4'd0;
      end else if (adv) begin
        phase_idx_q <= phase_idx_q + 4'd1;
      end
    end
  end

  assign gen_if.o_start_dropped = dropped_q;
  assign gen_if.o_phase_idx     = phase_idx_q;
`endif

endmodule

// File: tb/tb_hdr_exit_restart_gen.sv
// Directed bench for hdr_exit_restart_gen with PHASE_CYCLES=2.
// Latency: inputs are driven and outputs sampled 1 ns after each rising edge.
// Backpressure: none. A negedge bus monitor acts as the HDR exit/restart detector.
`timescale 1ns/1ps
module tb_hdr_exit_restart_gen;
  localparam int PH = 2;

  logic i_sys_clk_tb = 1'b0;
  logic i_sys_rst    = 1'b1;
  int   vectors      = 0;
  int   miscompares  = 0;

  hdr_exit_restart_gen_if bus_if ();

  hdr_exit_restart_gen #(.PHASE_CYCLES(PH), .CNT_W(4)) dut (
    .i_sys_clk (i_sys_clk_tb),
    .i_sys_rst (i_sys_rst),
    .gen_if    (bus_if)
  );

  always #5 i_sys_clk_tb = ~i_sys_clk_tb;

  // {scl, sda, oe, busy, done}
  logic [4:0] obs;
  assign obs = {bus_if.o_scl, bus_if.o_sda, bus_if.o_bus_oe, bus_if.o_gen_busy, bus_if.o_gen_done};

  // Hand-written {scl,sda} per phase
  logic [1:0] exit_ph [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] rst_ph  [7]  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};

  // Expected outputs for busy cycle cyc (1 = first cycle after start accepted)
  function automatic logic [4:0] exp_vec(input logic typ, input int cyc);
    int nph;
    int ph;
    nph = typ ? 7 : 10;
    if (cyc <= nph * PH) begin
      ph = (cyc - 1) / PH;
      return typ ? {rst_ph[ph], 3'b110} : {exit_ph[ph], 3'b110};
    end else if (cyc == nph * PH + 1) begin
      return 5'b11001;
    end
    return 5'b11000;
  endfunction

  // Loopback detector: counts SDA edges while SCL is low. An SDA rise with SCL high after 7 edges is an Exit, and after 3 edges a Restart.
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int   det_cnt = 0, det_seen = 0, det_exit = 0, det_restart = 0, viol = 0;

  always @(negedge i_sys_clk_tb) begin
    if (i_sys_rst) begin
      det_cnt  = 0;
      det_seen = 0;
    end else begin
      if ((bus_if.o_scl !== prev_scl) && (bus_if.o_sda !== prev_sda)) viol++;
      if (!bus_if.o_scl && !prev_scl && (bus_if.o_sda !== prev_sda)) det_cnt++;
      if (bus_if.o_scl && !prev_scl) begin
        det_seen = det_cnt;
        det_cnt  = 0;
      end
      if (bus_if.o_scl && prev_scl && bus_if.o_sda && !prev_sda) begin
        if (det_seen == 7) det_exit++;
        else if (det_seen == 3) det_restart++;
        det_seen = 0;
      end
    end
    prev_scl = bus_if.o_scl;
    prev_sda = bus_if.o_sda;
  end

  task automatic step();
    @(posedge i_sys_clk_tb);
    #1;
  endtask

  task automatic test_reset();
    i_sys_rst = 1'b1;
    repeat (3) step();
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_held got=%b want=%b", obs, 5'b11000);
    end
    i_sys_rst = 1'b0;
    step();
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_release got=%b want=%b", obs, 5'b11000);
    end
  endtask

  task automatic test_exit();
    int busy_cycles = 0;
    bus_if.i_gen_type  = 1'b0;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    bus_if.i_gen_type  = 1'b1;   // must not affect the running Exit
    for (int cyc = 1; cyc <= 10 * PH + 3; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, cyc)) begin
        miscompares++;
        $display("FAIL exit cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b0, cyc));
      end
      if (bus_if.o_gen_busy) busy_cycles++;
      step();
    end
    vectors++;
    if (busy_cycles != 20) begin
      miscompares++;
      $display("FAIL exit_busy_len got=%0d want=20", busy_cycles);
    end
    vectors++;
    if (det_exit != 1) begin
      miscompares++;
      $display("FAIL exit_detect got=%0d want=1", det_exit);
    end
  endtask

  task automatic test_restart();
    int busy_cycles = 0;
    bus_if.i_gen_type  = 1'b1;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    bus_if.i_gen_type  = 1'b0;
    for (int cyc = 1; cyc <= 7 * PH + 3; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b1, cyc)) begin
        miscompares++;
        $display("FAIL restart cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b1, cyc));
      end
      if (bus_if.o_gen_busy) busy_cycles++;
      step();
    end
    vectors++;
    if (busy_cycles != 14) begin
      miscompares++;
      $display("FAIL restart_busy_len got=%0d want=14", busy_cycles);
    end
    vectors++;
    if (det_restart != 1) begin
      miscompares++;
      $display("FAIL restart_detect got=%0d want=1", det_restart);
    end
  endtask

  // A start at cycle 5 (busy) and one in the DONE cycle are both ignored.
  task automatic test_start_while_busy();
    int busy_cycles = 0;
    bus_if.i_gen_type  = 1'b0;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    for (int cyc = 1; cyc <= 10 * PH + 4; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, cyc)) begin
        miscompares++;
        $display("FAIL busy_start cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b0, cyc));
      end
      if (bus_if.o_gen_busy) busy_cycles++;
      bus_if.i_gen_start = (cyc == 5) || (cyc == 10 * PH + 1);
      step();
    end
    bus_if.i_gen_start = 1'b0;
    vectors++;
    if (busy_cycles != 20) begin
      miscompares++;
      $display("FAIL busy_start_len got=%0d want=20", busy_cycles);
    end
    vectors++;
    if (det_exit != 2) begin
      miscompares++;
      $display("FAIL busy_start_detect got=%0d want=2", det_exit);
    end
  endtask

  task automatic test_abort();
    bus_if.i_gen_type  = 1'b0;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      vectors++;
      if (obs !== ((cyc <= 9) ? exp_vec(1'b0, cyc) : 5'b11000)) begin
        miscompares++;
        $display("FAIL abort cyc=%0d got=%b want=%b", cyc, obs,
                 (cyc <= 9) ? exp_vec(1'b0, cyc) : 5'b11000);
      end
      bus_if.i_gen_abort = (cyc == 9);
      step();
    end
    // Fresh start after abort must run the full sequence.
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    for (int cyc = 1; cyc <= 10 * PH + 3; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, cyc)) begin
        miscompares++;
        $display("FAIL post_abort cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b0, cyc));
      end
      step();
    end
    vectors++;
    if (det_exit != 3) begin
      miscompares++;
      $display("FAIL post_abort_detect got=%0d want=3", det_exit);
    end
  endtask

  task automatic test_abort_with_start();
    bus_if.i_gen_start = 1'b1;
    bus_if.i_gen_abort = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    bus_if.i_gen_abort = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      vectors++;
      if (obs !== 5'b11000) begin
        miscompares++;
        $display("FAIL abort_start cyc=%0d got=%b want=%b", cyc, obs, 5'b11000);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    bus_if.i_gen_type  = 1'b0;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, cyc)) begin
        miscompares++;
        $display("FAIL async_pre cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b0, cyc));
      end
      if (cyc < 6) step();
    end
    #3 i_sys_rst = 1'b1;   // between clock edges
    #1;
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL async_rst_immediate got=%b want=%b", obs, 5'b11000);
    end
    step();
    step();
    i_sys_rst = 1'b0;
    step();
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL async_rst_release got=%b want=%b", obs, 5'b11000);
    end
    bus_if.i_gen_type  = 1'b1;
    bus_if.i_gen_start = 1'b1;
    step();
    bus_if.i_gen_start = 1'b0;
    for (int cyc = 1; cyc <= 7 * PH + 3; cyc++) begin
      vectors++;
      if (obs !== exp_vec(1'b1, cyc)) begin
        miscompares++;
        $display("FAIL async_restart cyc=%0d got=%b want=%b", cyc, obs, exp_vec(1'b1, cyc));
      end
      step();
    end
    vectors++;
    if (det_restart != 2) begin
      miscompares++;
      $display("FAIL async_restart_detect got=%0d want=2", det_restart);
    end
  endtask

  initial begin
    bus_if.i_gen_start = 1'b0;
    bus_if.i_gen_type  = 1'b0;
    bus_if.i_gen_abort = 1'b0;
    test_reset();
    test_exit();
    test_restart();
    test_start_while_busy();
    test_abort();
    test_abort_with_start();
    test_async_reset();
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL scl_sda_same_cycle got=%0d want=0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
